// File: rtl/bus_cycle_fsm.sv
// bus_cycle_fsm: bus cycle sequencer for opcode fetch, memory read/write and I/O read/write.
// States IDLE/T1/T2/TW/T3/T4. Every bus output is a flop loaded from the decode of the next state.
// Optional feature macro: RFSH_EN adds a 7-bit refresh counter. When it is defined, the counter
// value goes out on the address bus with RFSH_L/MREQ_L during opcode-fetch T3/T4.
module bus_cycle_fsm #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int IO_WAITS = 1
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              start,
  input  logic [2:0]        cycle_type,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] data_in,
  input  logic              WAIT_L,
  output logic              ready,
  output logic              done,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              drive_addr,
  output logic              drive_data,
  output logic              M1_L,
  output logic              MREQ_L,
  output logic              IORQ_L,
  output logic              RD_L,
  output logic              WR_L,
  output logic              RFSH_L
);

  localparam logic [2:0] CT_OCF  = 3'd0;
  localparam logic [2:0] CT_MRD  = 3'd1;
  localparam logic [2:0] CT_MWR  = 3'd2;
  localparam logic [2:0] CT_IORD = 3'd3;
  localparam logic [2:0] CT_IOWR = 3'd4;

  // Forced I/O waits: flag, and the remaining count loaded when entering the first forced TW.
  localparam logic       HAS_FWAIT  = (IO_WAITS > 0) ? 1'b1 : 1'b0;
  localparam logic [1:0] FWAIT_LAST = (IO_WAITS > 0) ? 2'(IO_WAITS - 1) : 2'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_TW   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5
  } state_t;

  state_t     state_r;
  state_t     state_nx_s;
  logic [2:0] typ_r;
  logic [2:0] typ_nx_s;
  logic [1:0] wcnt_r;
  logic [1:0] wcnt_nx_s;
  logic       accept_s;
  logic       io_s;
  logic       ld_rd_s;

  logic ready_nx_s;
  logic done_nx_s;
  logic da_nx_s;
  logic dd_nx_s;
  logic m1_nx_s;
  logic mreq_nx_s;
  logic iorq_nx_s;
  logic rd_nx_s;
  logic wr_nx_s;
  logic rfsh_nx_s;

`ifdef RFSH_EN
  logic [6:0] rfsh_cnt_r;
  logic       rfsh_addr_s;
`endif

  // Acceptance, next-state sequencing, wait-state counting and read-capture decision.
  always_comb begin
    accept_s   = ready && start && (cycle_type <= CT_IOWR);
    typ_nx_s   = accept_s ? cycle_type : typ_r;
    io_s       = (typ_r == CT_IORD) || (typ_r == CT_IOWR);
    state_nx_s = state_r;
    wcnt_nx_s  = wcnt_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_nx_s = S_T1;
        else          state_nx_s = S_IDLE;
      end
      S_T1: state_nx_s = S_T2;
      S_T2: begin
        if (io_s && HAS_FWAIT) begin
          state_nx_s = S_TW;
          wcnt_nx_s  = FWAIT_LAST;
        end else if (!WAIT_L) begin
          state_nx_s = S_TW;
          wcnt_nx_s  = 2'd0;
        end else begin
          state_nx_s = S_T3;
          wcnt_nx_s  = 2'd0;
        end
      end
      S_TW: begin
        if (wcnt_r != 2'd0) begin
          state_nx_s = S_TW;
          wcnt_nx_s  = wcnt_r - 2'd1;
        end else if (!WAIT_L) begin
          state_nx_s = S_TW;
        end else begin
          state_nx_s = S_T3;
        end
      end
      S_T3: begin
        if (typ_r == CT_OCF) state_nx_s = S_T4;
        else if (accept_s)   state_nx_s = S_T1;
        else                 state_nx_s = S_IDLE;
      end
      S_T4: begin
        if (accept_s) state_nx_s = S_T1;
        else          state_nx_s = S_IDLE;
      end
      default: state_nx_s = S_IDLE;
    endcase

    // Opcode byte is taken when leaving the last T2/TW; read data when leaving T3.
    ld_rd_s = (((state_r == S_T2) || (state_r == S_TW)) && (state_nx_s == S_T3) && (typ_r == CT_OCF)) ||
              ((state_r == S_T3) && ((typ_r == CT_MRD) || (typ_r == CT_IORD)));
  end

  // Bus strobe and enable values for the state being entered.
  always_comb begin
    ready_nx_s = 1'b0;
    done_nx_s  = 1'b0;
    da_nx_s    = 1'b0;
    dd_nx_s    = 1'b0;
    m1_nx_s    = 1'b1;
    mreq_nx_s  = 1'b1;
    iorq_nx_s  = 1'b1;
    rd_nx_s    = 1'b1;
    wr_nx_s    = 1'b1;
    rfsh_nx_s  = 1'b1;
`ifdef RFSH_EN
    rfsh_addr_s = 1'b0;
`endif
    case (state_nx_s)
      S_IDLE: ready_nx_s = 1'b1;
      S_T1: begin
        da_nx_s = 1'b1;
        case (typ_nx_s)
          CT_OCF:  begin m1_nx_s = 1'b0; mreq_nx_s = 1'b0; rd_nx_s = 1'b0; end
          CT_MRD:  begin mreq_nx_s = 1'b0; rd_nx_s = 1'b0; end
          CT_MWR:  begin mreq_nx_s = 1'b0; dd_nx_s = 1'b1; end
          CT_IORD: begin end
          CT_IOWR: dd_nx_s = 1'b1;
          default: begin end
        endcase
      end
      S_T2, S_TW: begin
        da_nx_s = 1'b1;
        case (typ_nx_s)
          CT_OCF:  begin m1_nx_s = 1'b0; mreq_nx_s = 1'b0; rd_nx_s = 1'b0; end
          CT_MRD:  begin mreq_nx_s = 1'b0; rd_nx_s = 1'b0; end
          CT_MWR:  begin mreq_nx_s = 1'b0; wr_nx_s = 1'b0; dd_nx_s = 1'b1; end
          CT_IORD: begin iorq_nx_s = 1'b0; rd_nx_s = 1'b0; end
          CT_IOWR: begin iorq_nx_s = 1'b0; wr_nx_s = 1'b0; dd_nx_s = 1'b1; end
          default: begin end
        endcase
      end
      S_T3: begin
        if (typ_nx_s == CT_OCF) begin
`ifdef RFSH_EN
          mreq_nx_s   = 1'b0;
          rfsh_nx_s   = 1'b0;
          da_nx_s     = 1'b1;
          rfsh_addr_s = 1'b1;
`else
          da_nx_s = 1'b0;
`endif
        end else begin
          done_nx_s  = 1'b1;
          ready_nx_s = 1'b1;
          da_nx_s    = 1'b1;
          case (typ_nx_s)
            CT_MRD:  begin mreq_nx_s = 1'b0; rd_nx_s = 1'b0; end
            CT_MWR:  begin mreq_nx_s = 1'b0; wr_nx_s = 1'b0; dd_nx_s = 1'b1; end
            CT_IORD: begin iorq_nx_s = 1'b0; rd_nx_s = 1'b0; end
            CT_IOWR: begin iorq_nx_s = 1'b0; wr_nx_s = 1'b0; dd_nx_s = 1'b1; end
            default: begin end
          endcase
        end
      end
      S_T4: begin
        done_nx_s  = 1'b1;
        ready_nx_s = 1'b1;
`ifdef RFSH_EN
        mreq_nx_s   = 1'b0;
        rfsh_nx_s   = 1'b0;
        da_nx_s     = 1'b1;
        rfsh_addr_s = 1'b1;
`else
        da_nx_s = 1'b0;
`endif
      end
      default: ready_nx_s = 1'b1;
    endcase
  end

  // FSM state, captured cycle parameters and all registered bus outputs.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_r    <= S_IDLE;
      typ_r      <= 3'd0;
      wcnt_r     <= 2'd0;
      ready      <= 1'b1;
      done       <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      addr_out   <= '0;
      data_out   <= '0;
      drive_addr <= 1'b0;
      drive_data <= 1'b0;
      M1_L       <= 1'b1;
      MREQ_L     <= 1'b1;
      IORQ_L     <= 1'b1;
      RD_L       <= 1'b1;
      WR_L       <= 1'b1;
      RFSH_L     <= 1'b1;
`ifdef RFSH_EN
      rfsh_cnt_r <= 7'd0;
`endif
    end else begin
      state_r    <= state_nx_s;
      typ_r      <= typ_nx_s;
      wcnt_r     <= wcnt_nx_s;
      ready      <= ready_nx_s;
      done       <= done_nx_s;
      drive_addr <= da_nx_s;
      drive_data <= dd_nx_s;
      M1_L       <= m1_nx_s;
      MREQ_L     <= mreq_nx_s;
      IORQ_L     <= iorq_nx_s;
      RD_L       <= rd_nx_s;
      WR_L       <= wr_nx_s;
      RFSH_L     <= rfsh_nx_s;
      rd_valid   <= ld_rd_s;
      if (ld_rd_s) rd_data <= data_in;
      else         rd_data <= rd_data;
      // addr_out doubles as the address capture register; refresh overwrites it after T2.
      if (accept_s) begin
        addr_out <= addr_in;
        data_out <= wr_data;
      end
`ifdef RFSH_EN
      else if (rfsh_addr_s) begin
        addr_out <= {{(ADDR_W-7){1'b0}}, rfsh_cnt_r};
        data_out <= data_out;
      end
`endif
      else begin
        addr_out <= addr_out;
        data_out <= data_out;
      end
`ifdef RFSH_EN
      if (state_r == S_T4) rfsh_cnt_r <= rfsh_cnt_r + 7'd1;
      else                 rfsh_cnt_r <= rfsh_cnt_r;
`endif
    end
  end

endmodule
